// File: rtl/dmem_port_arbiter.sv
// Arbitrates the byte-lane DMem between the core MEM stage and an external loader port.
// Optional starvation guard for the external port is enabled by defining DMEM_ARB_FAIR_EN.
module dmem_port_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        core_req,
  input  logic [3:0]  core_we,
  input  logic [5:0]  core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_stall,
  output logic        core_rvalid,
  output logic [31:0] core_rdata,
  input  logic        ext_req,
  input  logic        ext_lock,
  input  logic [3:0]  ext_we,
  input  logic [5:0]  ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic [3:0]  mem_we,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CORE = 2'd1;
  localparam logic [1:0] S_EXT  = 2'd2;

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  if (MAX_BURST < 1 || STARVE_LIMIT < 1) begin : g_param_check
    $error("dmem_port_arbiter: MAX_BURST and STARVE_LIMIT must be >= 1");
  end

  logic [1:0]    state;
  logic [BW-1:0] burst_cnt;
  logic          core_rv_q;
  logic          ext_rv_q;
  logic          burst_cont;
  logic          starve;
  logic          core_gnt;
  logic          ext_gnt_i;

  assign burst_cont = (state == S_EXT) && ext_lock && ext_req && (burst_cnt < BURST_LAST);

`ifdef DMEM_ARB_FAIR_EN
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);

  logic [WW-1:0] wait_cnt;

  assign starve = ext_req && (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      wait_cnt <= '0;
    end else if (!ext_req || ext_gnt_i) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Priority: burst continuation, starvation guard, core, then ext.
  assign ext_gnt_i = nrst && (burst_cont || starve || (!core_req && ext_req));
  assign core_gnt  = nrst && !burst_cont && !starve && core_req;

  assign ext_gnt    = ext_gnt_i;
  assign core_stall = nrst && core_req && !core_gnt;

  always_comb begin
    mem_we   = 4'b0000;
    mem_addr = 6'd0;
    mem_din  = 32'd0;
    if (core_gnt) begin
      mem_we   = core_we;
      mem_addr = core_addr;
      mem_din  = core_wdata;
    end else if (ext_gnt_i) begin
      mem_we   = ext_we;
      mem_addr = ext_addr;
      mem_din  = ext_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
      core_rv_q <= 1'b0;
      ext_rv_q  <= 1'b0;
    end else begin
      core_rv_q <= core_gnt && (core_we == 4'b0000);
      ext_rv_q  <= ext_gnt_i && (ext_we == 4'b0000);
      if (core_gnt) begin
        state <= S_CORE;
      end else if (ext_gnt_i) begin
        state <= S_EXT;
      end else begin
        state <= S_IDLE;
      end
      // Saturates at the last burst slot so an unlocked ext run cannot wrap it.
      if (ext_gnt_i && (state == S_EXT)) begin
        if (burst_cnt != BURST_LAST) begin
          burst_cnt <= burst_cnt + 1'b1;
        end
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  // A read granted just before reset must not surface while reset is held.
  assign core_rvalid = core_rv_q && nrst;
  assign ext_rvalid  = ext_rv_q && nrst;
  assign core_rdata  = core_rvalid ? mem_dout : 32'd0;
  assign ext_rdata   = ext_rvalid ? mem_dout : 32'd0;

endmodule
